complex_mac_pipe: RTL
=====================

Name: complex_mac_pipe

Overview:
Parametrised, pipelined signed complex multiply / multiply-accumulate unit for the datapath. It is the successor to the fixed 8-bit single-cycle complex multiplier and adds generic component width, optional conjugation, a per-beat accumulate mode (complex dot product), guard bits with an overflow flag, and a valid/ready handshake in both directions. It sits between sample sources (FIFOs, correlators) and downstream consumers that may apply backpressure.

Parameters:
W, 8, width of each signed two's-complement component (re, im) of an input operand; legal range 4..16.
G, 4, accumulator guard bits.
OW, 2*W+1+G (derived localparam), width of each output component.

Ports:
Clk  in  1  clock; all state updates on the rising edge.
ResetN  in  1  asynchronous, active-low reset.
InValid  in  1  input beat valid.
InReady  out  1  input beat accepted when InValid && InReady.
InA  in  2W  operand A, {re[2W-1:W], im[W-1:0]}, signed.
InB  in  2W  operand B, same packing.
InConj  in  1  1 = use conj(B) (negate B.im) for this beat.
InMode  in  1  0 = plain multiply (every beat produces an output); 1 = accumulate.
InLast  in  1  mode 1 only: last beat of the accumulation group.
OutValid  out  1  result valid; held until OutReady.
OutReady  in  1  downstream ready.
OutResult  out  2*OW  {re[2*OW-1:OW], im[OW-1:0]}, signed.
OutOvf  out  1  1 = the result wrapped the OW-bit signed range.

Behaviour:
- Global stall: advance = !OutValid || OutReady; InReady = advance (combinational). When advance=0, every stage holds.
- S1 (on accept): register A, B, with B.im negated if InConj; also register Mode, Last, and a valid bit. Negation is computed at W+1 bits so -(-2^(W-1)) is exact.
- S2: four signed products ac, bd, ad, bc at full precision (2W+1 bits, to cover the conjugated case). Register re = ac - bd and im = ad + bc at 2W+1 bits. Both are exact: the (-2^(W-1))^2 * 2 case needs 2W+1 bits.
- S3 / output register, on advance with a valid S2 beat:
  - Mode 0: OutResult = sign-extended {re, im}; OutValid=1; OutOvf=0; accumulator state cleared.
  - Mode 1: acc = (group_start ? 0 : acc) + sign-extend(re, im), with wraparound at OW bits. The sticky overflow bit is set if either component's signed add overflows.
    - group_start is 1 after reset, after an InLast beat, and after any Mode 0 beat.
    - If Last: OutResult = acc, OutOvf = sticky flag, OutValid=1, next beat starts a new group.
    - Non-Last mode-1 beats produce no output (OutValid stays 0 unless a prior result is still held).
- Output handshake: OutValid clears on OutValid && OutReady unless a new result is loaded in the same cycle, in which case it stays 1 with the new data. OutResult and OutOvf are stable while OutValid && !OutReady.
- Latency: accepted beat to OutValid = 3 cycles with no backpressure. Throughput is 1 beat/clock when OutReady=1.
- Mixed modes: a mode-0 beat arriving mid-group terminates the group and discards the partial accumulation. The mode-0 result is output normally.
- Reset (ResetN=0, asynchronous, at any time including mid-group or while a result is held):
  - all stage valid bits, OutValid, OutOvf, accumulator, sticky flag and OutResult go to 0; group_start goes to 1.
  - InReady is 1 from the first cycle after reset release.

Test Plan:
- W=8, mode 0: A=(3,4), B=(1,2), OutReady=1 -> 3 cycles later OutResult=(-5,10), OutOvf=0, single OutValid pulse.
- Mode 0 with InConj=1: A=(3,4), B=(1,2) -> (11,-2). Extreme case A=B=(-128,-128), conj=0 -> (0,32768) with no wrap (17-bit product path checked).
- Mode 1: four beats A=B=(1,1), InLast on the 4th -> exactly one output (0,8), OutOvf=0. An immediately following group of one beat A=(2,0), B=(3,0), Last -> (6,0), confirming the accumulator cleared.
- Overflow, G=0: a mode-1 group of two beats (-128,-128)*(-128,-128) -> im wraps, OutOvf=1. A next mode-0 beat -> OutOvf=0.
- Backpressure: stream 6 mode-0 beats, hold OutReady=0 for 5 cycles -> InReady drops while the output is held; no result lost or duplicated; results emerge in order once OutReady=1.
- Reset mid-group: 2 of 4 mode-1 beats accepted, then pulse ResetN low -> outputs 0 immediately. After release, a fresh 1-beat group (1,0)*(5,0) -> (5,0).

Source files
------------

// File: rtl/complex_mac_pipe.sv
// Pipelined signed complex multiply / multiply-accumulate with optional conj(B) and a sticky overflow flag.
// Three-stage pipeline with a single global stall: every stage holds while a result waits on OutReady.
module complex_mac_pipe #(
  parameter int W  = 8,
  parameter int G  = 4,
  localparam int OW = 2*W + 1 + G
) (
  input  logic            Clk,
  input  logic            ResetN,
  input  logic            InValid,
  output logic            InReady,
  input  logic [2*W-1:0]  InA,
  input  logic [2*W-1:0]  InB,
  input  logic            InConj,
  input  logic            InMode,
  input  logic            InLast,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [2*OW-1:0] OutResult,
  output logic            OutOvf
);
  localparam int PW = 2*W + 1;

  logic advance;
  assign advance = !OutValid || OutReady;
  assign InReady = advance;

  logic                s1_vld_q, s1_vld_d, s1_mode_q, s1_mode_d, s1_last_q, s1_last_d;
  logic signed [W-1:0] s1_are_q, s1_are_d, s1_aim_q, s1_aim_d, s1_bre_q, s1_bre_d;
  logic signed [W:0]   s1_bim_q, s1_bim_d;

  logic                 s2_vld_q, s2_vld_d, s2_mode_q, s2_mode_d, s2_last_q, s2_last_d;
  logic signed [PW-1:0] s2_re_q, s2_re_d, s2_im_q, s2_im_d;
  logic signed [PW-1:0] are_x, aim_x, bre_x, bim_x;

  logic                 out_vld_q, out_vld_d, out_ovf_q, out_ovf_d;
  logic signed [OW-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic signed [OW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic                 sticky_q, sticky_d, grp_start_q, grp_start_d;
  logic signed [OW-1:0] re_x, im_x, base_re, base_im, sum_re, sum_im;
  logic                 ovf_re, ovf_im, sticky_new;

  // Stage 1: conj negation at W+1 bits so the most negative B.im negates exactly.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_mode_d = s1_mode_q;
    s1_last_d = s1_last_q;
    s1_are_d  = s1_are_q;
    s1_aim_d  = s1_aim_q;
    s1_bre_d  = s1_bre_q;
    s1_bim_d  = s1_bim_q;
    if (advance) begin
      s1_vld_d  = InValid;
      s1_mode_d = InMode;
      s1_last_d = InLast;
      s1_are_d  = InA[2*W-1:W];
      s1_aim_d  = InA[W-1:0];
      s1_bre_d  = InB[2*W-1:W];
      s1_bim_d  = InConj ? -$signed({InB[W-1], InB[W-1:0]}) : $signed({InB[W-1], InB[W-1:0]});
    end
  end

  // Stage 2: operands widened to PW first, so every product and the sum/difference are exact.
  always_comb begin
    are_x     = s1_are_q;
    aim_x     = s1_aim_q;
    bre_x     = s1_bre_q;
    bim_x     = s1_bim_q;
    s2_vld_d  = s2_vld_q;
    s2_mode_d = s2_mode_q;
    s2_last_d = s2_last_q;
    s2_re_d   = s2_re_q;
    s2_im_d   = s2_im_q;
    if (advance) begin
      s2_vld_d  = s1_vld_q;
      s2_mode_d = s1_mode_q;
      s2_last_d = s1_last_q;
      s2_re_d   = are_x * bre_x - aim_x * bim_x;
      s2_im_d   = are_x * bim_x + aim_x * bre_x;
    end
  end

  // Stage 3: accumulate with wraparound; overflow is a same-sign add giving an opposite-sign sum.
  always_comb begin
    re_x        = s2_re_q;
    im_x        = s2_im_q;
    base_re     = grp_start_q ? '0 : acc_re_q;
    base_im     = grp_start_q ? '0 : acc_im_q;
    sum_re      = base_re + re_x;
    sum_im      = base_im + im_x;
    ovf_re      = (base_re[OW-1] == re_x[OW-1]) && (sum_re[OW-1] != base_re[OW-1]);
    ovf_im      = (base_im[OW-1] == im_x[OW-1]) && (sum_im[OW-1] != base_im[OW-1]);
    sticky_new  = (grp_start_q ? 1'b0 : sticky_q) | ovf_re | ovf_im;
    out_vld_d   = out_vld_q;
    out_ovf_d   = out_ovf_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    acc_re_d    = acc_re_q;
    acc_im_d    = acc_im_q;
    sticky_d    = sticky_q;
    grp_start_d = grp_start_q;
    if (advance) begin
      out_vld_d = 1'b0;
      if (s2_vld_q && !s2_mode_q) begin
        out_vld_d   = 1'b1;
        out_re_d    = re_x;
        out_im_d    = im_x;
        out_ovf_d   = 1'b0;
        acc_re_d    = '0;
        acc_im_d    = '0;
        sticky_d    = 1'b0;
        grp_start_d = 1'b1;
      end else if (s2_vld_q) begin
        acc_re_d    = sum_re;
        acc_im_d    = sum_im;
        sticky_d    = sticky_new;
        grp_start_d = s2_last_q;
        if (s2_last_q) begin
          out_vld_d = 1'b1;
          out_re_d  = sum_re;
          out_im_d  = sum_im;
          out_ovf_d = sticky_new;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      s1_vld_q    <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_are_q    <= '0;
      s1_aim_q    <= '0;
      s1_bre_q    <= '0;
      s1_bim_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_mode_q   <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_re_q     <= '0;
      s2_im_q     <= '0;
      out_vld_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      sticky_q    <= 1'b0;
      grp_start_q <= 1'b1;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_mode_q   <= s1_mode_d;
      s1_last_q   <= s1_last_d;
      s1_are_q    <= s1_are_d;
      s1_aim_q    <= s1_aim_d;
      s1_bre_q    <= s1_bre_d;
      s1_bim_q    <= s1_bim_d;
      s2_vld_q    <= s2_vld_d;
      s2_mode_q   <= s2_mode_d;
      s2_last_q   <= s2_last_d;
      s2_re_q     <= s2_re_d;
      s2_im_q     <= s2_im_d;
      out_vld_q   <= out_vld_d;
      out_ovf_q   <= out_ovf_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      sticky_q    <= sticky_d;
      grp_start_q <= grp_start_d;
    end
  end

  assign OutValid  = out_vld_q;
  assign OutOvf    = out_ovf_q;
  assign OutResult = {out_re_q, out_im_q};
endmodule
